// File: rtl/mem_stim_gen_if.sv
// Transaction bus between the stimulus generator (master) and the device under test (slave).
// One transfer happens on every cycle where valid and ready are both high.
interface mem_stim_gen_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] exp_data;

  modport master (
    output valid, wr_en, rd_en, addr, wdata, exp_data,
    input  ready
  );

  modport slave (
    input  valid, wr_en, rd_en, addr, wdata, exp_data,
    output ready
  );
endinterface

// File: rtl/mem_stim_gen.sv
// Write-then-read memory-test stimulus source: N LFSR-data writes to addresses 0..N-1, then N reads with expected data.
// All outputs are registered; the first transaction appears one cycle after start; a stall (ready low) freezes the transaction.
module mem_stim_gen #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_txn,
  mem_stim_gen_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH+1:0] txn_count
);

  localparam int          CW       = ADDR_WIDTH + 2;
  localparam int          NW       = ADDR_WIDTH + 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Galois form, right shift, taps 16'hB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  state_t                state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wr_lfsr_q, wr_lfsr_d;
  logic [15:0]           rd_lfsr_q, rd_lfsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  valid_q, valid_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic xfer;
  logic last_addr;

  assign xfer      = valid_q && bus.ready;
  assign last_addr = ({1'b0, addr_q} == (n_q - NW'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      addr_q    <= '0;
      wr_lfsr_q <= SEED_EFF;
      rd_lfsr_q <= SEED_EFF;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      wr_lfsr_q <= wr_lfsr_d;
      rd_lfsr_q <= rd_lfsr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    wr_lfsr_d = wr_lfsr_q;
    rd_lfsr_d = rd_lfsr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d       = num_txn;
          wr_lfsr_d = SEED_EFF;
          rd_lfsr_d = SEED_EFF;
          addr_d    = '0;
          cnt_d     = '0;
          state_d   = (num_txn == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          wr_lfsr_d = lfsr_step(wr_lfsr_q);
          cnt_d     = cnt_q + CW'(1);
          if (last_addr) begin
            addr_d  = '0;
            state_d = ST_READ;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_READ: begin
        if (xfer) begin
          rd_lfsr_d = lfsr_step(rd_lfsr_q);
          cnt_d     = cnt_q + CW'(1);
          addr_d    = addr_q + ADDR_WIDTH'(1);
          if (last_addr) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered without adding latency.
  always_comb begin
    valid_d    = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_out_d = '0;
    wdata_d    = '0;
    exp_d      = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_d)
      ST_WRITE: begin
        valid_d    = 1'b1;
        wr_en_d    = 1'b1;
        busy_d     = 1'b1;
        addr_out_d = addr_d;
        wdata_d    = wr_lfsr_d[DATA_WIDTH-1:0];
      end
      ST_READ: begin
        valid_d    = 1'b1;
        rd_en_d    = 1'b1;
        busy_d     = 1'b1;
        addr_out_d = addr_d;
        exp_d      = rd_lfsr_d[DATA_WIDTH-1:0];
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_out_q <= '0;
      wdata_q    <= '0;
      exp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_out_q <= addr_out_d;
      wdata_q    <= wdata_d;
      exp_q      <= exp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.addr     = addr_out_q;
  assign bus.wdata    = wdata_q;
  assign bus.exp_data = exp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign txn_count    = cnt_q;

endmodule

// File: tb/tb_mem_stim_gen.sv
// Directed bench for mem_stim_gen: a table of per-cycle vectors plus a full 16-deep run against an LFSR model.
module tb_mem_stim_gen;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_txn;
  logic          busy;
  logic          done;
  logic [AW+1:0] txn_count;

  mem_stim_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_stim_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_txn   (num_txn),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          st;
    logic [AW:0]   num;
    logic          rdy;
    logic [30:0]   exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Packs the expected output image: {valid,wr_en,rd_en,addr,wdata,exp_data,busy,done,txn_count}.
  function automatic logic [30:0] img(input logic v, input logic w, input logic r,
                                      input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                      input logic [DW-1:0] ex, input logic b, input logic d,
                                      input logic [AW+1:0] c);
    return {v, w, r, a, wd, ex, b, d, c};
  endfunction

  function automatic vec_t mk(input logic rst, input logic st, input logic [AW:0] num,
                              input logic rdy, input logic [30:0] e);
    vec_t t;
    t.rst = rst; t.st = st; t.num = num; t.rdy = rdy; t.exp = e;
    return t;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [30:0] actual();
    return {bus.valid, bus.wr_en, bus.rd_en, bus.addr, bus.wdata, bus.exp_data, busy, done, txn_count};
  endfunction

  task automatic check(input string name, input logic [30:0] act, input logic [30:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic step(input logic rst, input logic st, input logic [AW:0] num, input logic rdy);
    reset     = rst;
    start     = st;
    num_txn   = num;
    bus.ready = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [30:0] ZERO;
  logic [30:0] e;
  logic [15:0] ws, rs;

  initial begin
    ZERO = '0;
    reset = 1'b1; start = 1'b0; num_txn = '0; bus.ready = 1'b0;

    // N=3 run with a 4-cycle stall on write address 1
    vecs.push_back(mk(1, 0, 0, 0, ZERO));
    vecs.push_back(mk(0, 1, 3, 1, img(1, 1, 0, 0, 8'hE1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 1, 0, 1, 8'h70, 0, 1, 0, 1)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, img(1, 1, 0, 1, 8'h70, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 1, 0, 2, 8'h38, 0, 1, 0, 2)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 0, 1, 0, 0, 8'hE1, 1, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 0, 1, 1, 0, 8'h70, 1, 0, 4)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 0, 1, 2, 0, 8'h38, 1, 0, 5)));
    vecs.push_back(mk(0, 0, 0, 1, img(0, 0, 0, 0, 0, 0, 0, 1, 6)));
    vecs.push_back(mk(0, 0, 0, 1, img(0, 0, 0, 0, 0, 0, 0, 1, 6)));
    // num_txn=0 from DONE and from IDLE
    vecs.push_back(mk(0, 1, 0, 1, img(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk(1, 0, 0, 0, ZERO));
    vecs.push_back(mk(0, 1, 0, 1, img(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 1, img(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    // start while busy is ignored; start in DONE restarts
    vecs.push_back(mk(1, 0, 0, 1, ZERO));
    vecs.push_back(mk(0, 1, 2, 1, img(1, 1, 0, 0, 8'hE1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, 3, 1, img(1, 1, 0, 1, 8'h70, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 1, 3, 1, img(1, 0, 1, 0, 0, 8'hE1, 1, 0, 2)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 0, 1, 1, 0, 8'h70, 1, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 1, img(0, 0, 0, 0, 0, 0, 0, 1, 4)));
    vecs.push_back(mk(0, 1, 2, 1, img(1, 1, 0, 0, 8'hE1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 1, 0, 1, 8'h70, 0, 1, 0, 1)));
    // reset during READ at address 2, then replay
    vecs.push_back(mk(1, 0, 0, 1, ZERO));
    vecs.push_back(mk(0, 1, 3, 1, img(1, 1, 0, 0, 8'hE1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 1, 0, 1, 8'h70, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 1, 0, 2, 8'h38, 0, 1, 0, 2)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 0, 1, 0, 0, 8'hE1, 1, 0, 3)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 0, 1, 1, 0, 8'h70, 1, 0, 4)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 0, 1, 2, 0, 8'h38, 1, 0, 5)));
    vecs.push_back(mk(1, 0, 0, 1, ZERO));
    vecs.push_back(mk(0, 1, 3, 1, img(1, 1, 0, 0, 8'hE1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, img(1, 1, 0, 1, 8'h70, 0, 1, 0, 1)));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].num, vecs[i].rdy);
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // Full-depth run: addresses wrap at 2^ADDR_WIDTH, reads replay the write data
    step(1, 0, 0, 0);
    check("full_reset", actual(), ZERO);
    step(0, 1, 16, 1);
    ws = 16'hACE1;
    rs = 16'hACE1;
    for (int i = 0; i < 32; i++) begin
      if (i < 16) begin
        e  = img(1, 1, 0, AW'(i), ws[DW-1:0], 0, 1, 0, (AW+2)'(i));
        ws = lfsr_next(ws);
      end else begin
        e  = img(1, 0, 1, AW'(i - 16), 0, rs[DW-1:0], 1, 0, (AW+2)'(i));
        rs = lfsr_next(rs);
      end
      check($sformatf("full%0d", i), actual(), e);
      step(0, 0, 0, 1);
    end
    check("full_done", actual(), img(0, 0, 0, 0, 0, 0, 0, 1, 32));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stim_gen.md
# mem_stim_gen

Synthesizable stimulus source that sits directly upstream of the DUT on the shared interface. It drives a write-then-read memory-test transaction stream. On `start`, it issues N writes of LFSR-generated data to addresses 0..N-1, then N reads of the same addresses. Alongside each read it presents the expected data, so a downstream checker can compare without a scoreboard.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: address width; max transactions per phase is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 8: write/expected data width; must be ≤16.
- `SEED`, default 16'hACE1: LFSR seed; the value 0 is replaced by 16'h0001.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a test run; sampled only in IDLE or DONE.
- `num_txn`, input, ADDR_WIDTH+1: transactions per phase; latched when `start` is accepted.
- `ready`, input, 1: DUT accepts the current transaction.
- `valid`, output, 1: transaction present on the outputs.
- `wr_en`, output, 1: current transaction is a write.
- `rd_en`, output, 1: current transaction is a read.
- `addr`, output, ADDR_WIDTH: transaction address.
- `wdata`, output, DATA_WIDTH: write data; 0 during reads.
- `exp_data`, output, DATA_WIDTH: expected read data; 0 during writes.
- `busy`, output, 1: high in WRITE or READ.
- `done`, output, 1: high while in DONE.
- `txn_count`, output, ADDR_WIDTH+2: accepted handshakes in the current run.

## Operation
- States:
  - IDLE: all outputs 0.
  - WRITE: `valid`=1, `wr_en`=1.
  - READ: `valid`=1, `rd_en`=1.
  - DONE: `done`=1, other outputs hold 0 except `txn_count`, which holds its final value.
- IDLE or DONE with `start`=1:
  - latch `num_txn`; reload both LFSRs with SEED; clear `addr` and `txn_count`.
  - If `num_txn`=0, go to DONE; otherwise go to WRITE.
- Handshake:
  - A transfer occurs on any cycle with `valid && ready`.
  - While `valid`=1 and `ready`=0, `addr`, `wdata`, `exp_data`, `wr_en` and `rd_en` hold stable.
- WRITE:
  - `wdata` = wr_lfsr[DATA_WIDTH-1:0].
  - On each transfer: wr_lfsr steps, `addr` increments, `txn_count` increments.
  - On the transfer at `addr`=N-1: `addr` wraps to 0 and the state moves to READ.
- READ:
  - `exp_data` = rd_lfsr[DATA_WIDTH-1:0]; rd_lfsr replays the same sequence from SEED.
  - On each transfer: rd_lfsr steps, `addr` increments, `txn_count` increments.
  - On the transfer at `addr`=N-1: go to DONE.
- LFSR: 16-bit Galois, right shift.
  - If lsb=1: next = (s>>1) ^ 16'hB400.
  - Otherwise: next = s>>1.
- Width rules:
  - With N = 2^ADDR_WIDTH, `addr` wraps naturally from all-ones to 0.
  - Final `txn_count` = 2N.
- `start` while `busy`: ignored.
- `reset` at any time, including mid-phase or during a stalled handshake:
  - next state IDLE; all outputs 0; both LFSRs reload SEED; latched count cleared.

## Timing
- Reset values:
  - `valid`, `wr_en`, `rd_en`, `busy`, `done` = 0.
  - `addr`, `wdata`, `exp_data`, `txn_count` = 0.
- All outputs are registered.
- `start` at edge k: `valid`=1 with `addr`=0 and first `wdata`=SEED[DATA_WIDTH-1:0] after edge k.
- Throughput: one transfer per cycle when `ready` is held high.
- WRITE→READ is back-to-back: the cycle after the last write transfer shows the read of address 0, with no bubble.
- Last read transfer at edge m: `done`=1 and `valid`=0 after edge m.
- With `ready` tied high and N≥1, a run spans 2N cycles from first `valid` to `done`.

## Test plan
- Reset, then `start` with `num_txn`=3 and `ready`=1:
  - writes: addr 0/1/2 with wdata 8'hE1/8'h70/8'h38.
  - reads: addr 0/1/2 with exp_data 8'hE1/8'h70/8'h38.
  - then `done`=1 and `txn_count`=6.
- `ready` held low for 4 cycles at write addr 1: `addr`=1 and `wdata`=8'h70 stay stable for all 4 cycles; the sequence then resumes unchanged.
- `num_txn`=0: `done`=1 one cycle after `start`; `valid` never asserts; `txn_count`=0.
- `num_txn`=16 with ADDR_WIDTH=4:
  - `addr` runs 0..15, wraps to 0 in READ, ends at 15.
  - `txn_count`=32.
  - first read `exp_data` equals the first `wdata`.
- `reset` asserted during READ at addr 2:
  - all outputs 0 on the next cycle.
  - a subsequent `start` replays the identical sequence starting 8'hE1.
- `start` pulsed while `busy` and again in DONE:
  - the first pulse is ignored.
  - the second restarts the run from addr 0 with the same data.
